uart_trx: RTL and testbench

// - 8N1 UART transceiver: a transmit path serialises bytes and a receive path deserialises them.
// - TX serialiser: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
// - RX deserialiser: 2-FF synchronised input, mid-bit sampling, 8N1 framing.
// - Sits between a byte-wide core interface and the board UART pins; the TX and RX paths are independent.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_trx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_trx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_trx transceiver: FSM state encodings
// and the clock-to-baud divisor calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [3:0] LAST_DATA_BIT = 4'd7;

   // Truncating divide; the caller guarantees the result is at least 4.
   function automatic int unsigned baud_div(input int unsigned clk_rate, input int unsigned baud);
      return clk_rate / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..DIV-1 and wraps, with a synchronous load-to-zero,
// a terminal-count flag (last clock of a bit) and a half-period flag.
module uart_baud_cnt #(
   parameter int unsigned DIV = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tc,
   output logic half
);

   localparam int unsigned CW = $clog2(DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc   = (cnt == LAST);
   assign half = (cnt == MID);

endmodule

// File: rtl/uart_trx.sv
// 8N1 UART transceiver with independent TX serialiser and RX deserialiser.
// Optional macro UART_RX_STOP_CHECK_EN: drop received bytes whose stop bit is 0.
//
// TX FSM   state    | meaning
//          TX_IDLE  | line high, waiting for uart_tx_evt_i
//          TX_START | driving start bit (0) for one bit time
//          TX_DATA  | driving data bit tx_idx, LSB first
//          TX_STOP  | driving stop bit (1); done pulses as it ends
// RX FSM   state    | meaning
//          RX_IDLE  | waiting for a 1->0 edge on the synchronised line
//          RX_START | waiting half a bit to confirm the start bit
//          RX_DATA  | sampling data bit rx_idx mid-bit
//          RX_STOP  | sampling the stop bit, then delivering the byte
module uart_trx #(
   parameter logic [31:0] MODULE_CLK_RATE   = 32'd100_000_000,
   parameter logic [31:0] UART_BAUDCLK_RATE = 32'd115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] uart_tx_data_i,
   input  logic       uart_tx_evt_i,
   output logic       uart_tx,
   output logic       uart_tx_done,
   input  logic       uart_rx,
   output logic       uart_rx_evt_o,
   output logic [7:0] uart_rx_data_o,
   output logic       baud_bps_tb
);

   import uart_pkg::*;

   localparam int unsigned BAUD_DIV = baud_div(MODULE_CLK_RATE, UART_BAUDCLK_RATE);

   tx_state_t  tx_state, tx_state_nxt;
   logic [3:0] tx_idx, tx_idx_nxt;
   logic [7:0] tx_byte, tx_byte_nxt;
   logic       tx_line_nxt;
   logic       tx_done_nxt;
   logic       tx_load;
   logic       tx_tc;
   logic       tx_half_unused;

   uart_baud_cnt #(.DIV(BAUD_DIV)) u_tx_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (tx_load),
      .tc   (tx_tc),
      .half (tx_half_unused)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state     <= TX_IDLE;
         tx_idx       <= '0;
         tx_byte      <= '0;
         uart_tx      <= 1'b1;
         uart_tx_done <= 1'b0;
      end else begin
         tx_state     <= tx_state_nxt;
         tx_idx       <= tx_idx_nxt;
         tx_byte      <= tx_byte_nxt;
         uart_tx      <= tx_line_nxt;
         uart_tx_done <= tx_done_nxt;
      end
   end

   // The line level is computed from the next state so uart_tx is a flop output.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_idx_nxt   = tx_idx;
      tx_byte_nxt  = tx_byte;
      tx_done_nxt  = 1'b0;
      tx_line_nxt  = 1'b1;
      tx_load      = (tx_state == TX_IDLE);
      case (tx_state)
         TX_IDLE: begin
            if (uart_tx_evt_i) begin
               tx_state_nxt = TX_START;
               tx_byte_nxt  = uart_tx_data_i;
               tx_idx_nxt   = '0;
            end
         end
         TX_START: begin
            if (tx_tc) begin
               tx_state_nxt = TX_DATA;
               tx_idx_nxt   = '0;
            end
         end
         TX_DATA: begin
            if (tx_tc) begin
               if (tx_idx == LAST_DATA_BIT) begin
                  tx_state_nxt = TX_STOP;
               end else begin
                  tx_idx_nxt = tx_idx + 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tx_tc) begin
               tx_state_nxt = TX_IDLE;
               tx_done_nxt  = 1'b1;
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
      case (tx_state_nxt)
         TX_START: tx_line_nxt = 1'b0;
         TX_DATA:  tx_line_nxt = tx_byte_nxt[tx_idx_nxt[2:0]];
         default:  tx_line_nxt = 1'b1;
      endcase
   end

   logic [1:0] rx_sync;
   logic       rx_s;
   logic       rx_prev;
   rx_state_t  rx_state, rx_state_nxt;
   logic [3:0] rx_idx, rx_idx_nxt;
   logic [7:0] rx_shift, rx_shift_nxt;
   logic       rx_load;
   logic       rx_sample;
   logic       rx_accept;
   logic       rx_tc;
   logic       rx_half;

   assign rx_s = rx_sync[1];

   uart_baud_cnt #(.DIV(BAUD_DIV)) u_rx_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (rx_load),
      .tc   (rx_tc),
      .half (rx_half)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_sync        <= 2'b11;
         rx_prev        <= 1'b1;
         rx_state       <= RX_IDLE;
         rx_idx         <= '0;
         rx_shift       <= '0;
         uart_rx_evt_o  <= 1'b0;
         uart_rx_data_o <= '0;
         baud_bps_tb    <= 1'b0;
      end else begin
         rx_sync       <= {rx_sync[0], uart_rx};
         rx_prev       <= rx_s;
         rx_state      <= rx_state_nxt;
         rx_idx        <= rx_idx_nxt;
         rx_shift      <= rx_shift_nxt;
         uart_rx_evt_o <= rx_accept;
         baud_bps_tb   <= rx_sample;
         if (rx_accept) begin
            uart_rx_data_o <= rx_shift;
         end
      end
   end

   // Start detection needs rx_prev=1, so after a low stop bit the receiver
   // cannot re-arm until the line has returned high.
   always_comb begin
      rx_state_nxt = rx_state;
      rx_idx_nxt   = rx_idx;
      rx_shift_nxt = rx_shift;
      rx_load      = 1'b0;
      rx_sample    = 1'b0;
      rx_accept    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_load = 1'b1;
            if (rx_prev && !rx_s) begin
               rx_state_nxt = RX_START;
               rx_idx_nxt   = '0;
            end
         end
         RX_START: begin
            if (rx_half) begin
               rx_sample    = 1'b1;
               rx_load      = 1'b1;
               rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_tc) begin
               rx_sample    = 1'b1;
               rx_shift_nxt = {rx_s, rx_shift[7:1]};
               if (rx_idx == LAST_DATA_BIT) begin
                  rx_state_nxt = RX_STOP;
               end else begin
                  rx_idx_nxt = rx_idx + 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (rx_tc) begin
               rx_sample    = 1'b1;
               rx_state_nxt = RX_IDLE;
`ifdef UART_RX_STOP_CHECK_EN
               rx_accept    = rx_s;
`else
               rx_accept    = 1'b1;
`endif
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx at a 16-clock bit time: loopback, line shape,
// busy-ignore, back-to-back, glitch, framing and mid-frame reset.
module tb_uart_trx;

   localparam int DIV = 16;
`ifdef UART_RX_STOP_CHECK_EN
   localparam int STOP_CHK = 1;
`else
   localparam int STOP_CHK = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_evt = 1'b0;
   logic       uart_tx;
   logic       tx_done;
   logic       uart_rx;
   logic       rx_evt;
   logic [7:0] rx_data;
   logic       bps;
   logic       loop = 1'b1;
   logic       rx_drv = 1'b1;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int bps_cnt = 0;
   logic [7:0] rx_q[$];

   assign uart_rx = loop ? uart_tx : rx_drv;

   always #5 clk = ~clk;

   uart_trx #(
      .MODULE_CLK_RATE   (32'd1_843_200),
      .UART_BAUDCLK_RATE (32'd115_200)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .uart_tx_data_i (tx_data),
      .uart_tx_evt_i  (tx_evt),
      .uart_tx        (uart_tx),
      .uart_tx_done   (tx_done),
      .uart_rx        (uart_rx),
      .uart_rx_evt_o  (rx_evt),
      .uart_rx_data_o (rx_data),
      .baud_bps_tb    (bps)
   );

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (bps) bps_cnt++;
      if (rx_evt) rx_q.push_back(rx_data);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends one byte in loopback and checks every cycle of the frame.
   task automatic send_line(input logic [7:0] d);
      int   b0;
      int   slot;
      logic exp_tx;
      b0 = bps_cnt;
      @(negedge clk);
      tx_data = d;
      tx_evt  = 1'b1;
      for (int i = 1; i <= 162; i++) begin
         @(negedge clk);
         if (i == 1) begin
            tx_evt  = 1'b0;
            tx_data = ~d;
         end
         slot = (i - 1) / DIV;
         if (i > 160)        exp_tx = 1'b1;
         else if (slot == 0) exp_tx = 1'b0;
         else if (slot == 9) exp_tx = 1'b1;
         else                exp_tx = d[slot-1];
         chk("tx_line", {31'd0, uart_tx}, {31'd0, exp_tx});
         chk("tx_done", {31'd0, tx_done}, {31'd0, i == 161});
         chk("rx_evt", {31'd0, rx_evt}, {31'd0, i == 156});
         if (i == 156) chk("rx_data", {24'd0, rx_data}, {24'd0, d});
      end
      chk("bps_count", bps_cnt - b0, 10);
   endtask

   task automatic rx_drive(input logic [7:0] d, input logic stop);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx_drv = fr[b];
         repeat (DIV) @(negedge clk);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         q0;
      int         d0;
      int         b0;
      bit         got;
      logic [7:0] bb[16];
      logic [8:0] gb;

      #12;
      chk("rst_tx", {31'd0, uart_tx}, 1);
      chk("rst_done", {31'd0, tx_done}, 0);
      chk("rst_evt", {31'd0, rx_evt}, 0);
      chk("rst_data", {24'd0, rx_data}, 0);
      chk("rst_bps", {31'd0, bps}, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      send_line(8'hA5);
      send_line(8'h01);

      // second request in the middle of a frame must be dropped
      q0 = rx_q.size();
      d0 = done_cnt;
      @(negedge clk);
      tx_data = 8'h3C;
      tx_evt  = 1'b1;
      @(negedge clk);
      tx_evt = 1'b0;
      repeat (99) @(negedge clk);
      tx_data = 8'hFF;
      tx_evt  = 1'b1;
      @(negedge clk);
      tx_evt = 1'b0;
      repeat (300) @(negedge clk);
      chk("busy_done_count", done_cnt - d0, 1);
      chk("busy_rx_count", rx_q.size() - q0, 1);
      chk("busy_rx_byte", {24'd0, rx_data}, 32'h3C);

      for (int k = 0; k < 16; k++) bb[k] = 8'($urandom_range(0, 255));
      q0 = rx_q.size();
      d0 = done_cnt;
      @(negedge clk);
      tx_data = bb[0];
      tx_evt  = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         tx_evt = 1'b0;
         if (k > 1) chk("b2b_start", {31'd0, uart_tx}, 0);
         got = 1'b0;
         for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (tx_done) got = 1'b1;
         end
         chk("b2b_done_wait", {31'd0, got}, 1);
         if (k < 16) begin
            tx_data = bb[k];
            tx_evt  = 1'b1;
         end
      end
      repeat (40) @(negedge clk);
      chk("b2b_done_count", done_cnt - d0, 16);
      chk("b2b_rx_count", rx_q.size() - q0, 16);
      for (int k = 0; k < 16; k++) begin
         gb = (rx_q.size() > q0 + k) ? {1'b0, rx_q[q0+k]} : 9'h1FF;
         chk("b2b_rx_byte", {23'd0, gb}, {24'd0, bb[k]});
      end

      // short low pulse on the line is rejected at the start re-sample
      @(negedge clk);
      loop   = 1'b0;
      rx_drv = 1'b1;
      repeat (5) @(negedge clk);
      b0 = bps_cnt;
      q0 = rx_q.size();
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      chk("glitch_no_evt", rx_q.size() - q0, 0);
      chk("glitch_one_sample", bps_cnt - b0, 1);

      q0 = rx_q.size();
      rx_drive(8'h96, 1'b1);
      repeat (2 * DIV) @(negedge clk);
      chk("after_glitch_count", rx_q.size() - q0, 1);
      chk("after_glitch_data", {24'd0, rx_data}, 32'h96);

      q0 = rx_q.size();
      rx_drive(8'h5A, 1'b0);
      repeat (2 * DIV) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      chk("frame_err_count", rx_q.size() - q0, (STOP_CHK != 0) ? 0 : 1);
      chk("frame_err_data", {24'd0, rx_data}, (STOP_CHK != 0) ? 32'h96 : 32'h5A);
      q0 = rx_q.size();
      rx_drive(8'hC3, 1'b1);
      repeat (2 * DIV) @(negedge clk);
      chk("after_frame_err_count", rx_q.size() - q0, 1);
      chk("after_frame_err_data", {24'd0, rx_data}, 32'hC3);

      // reset in the middle of a loopback frame
      loop = 1'b1;
      repeat (4) @(negedge clk);
      q0 = rx_q.size();
      d0 = done_cnt;
      tx_data = 8'h4E;
      tx_evt  = 1'b1;
      @(negedge clk);
      tx_evt = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_tx", {31'd0, uart_tx}, 1);
      chk("midrst_data", {24'd0, rx_data}, 0);
      chk("midrst_evt", {31'd0, rx_evt}, 0);
      chk("midrst_done", {31'd0, tx_done}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (200) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_no_evt", rx_q.size() - q0, 0);
      send_line(8'h69);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
